// File: rtl/bank_xbar_rsp_rob_pkg.sv
// rtl/bank_xbar_rsp_rob_pkg.sv - shared sizes and types for the bank response reorder buffer
package bank_xbar_rob_pkg;

  localparam int XBAR_NUM_CH    = 3;
  localparam int XBAR_ROB_DEPTH = 8;
  localparam int XBAR_ROB_PTR_W = 4;
  localparam int XBAR_DATA_W    = 128;

  typedef logic [2:0]                xbar_rob_num_t;
  typedef logic [1:0]                xbar_ch_id_t;
  typedef logic [XBAR_ROB_PTR_W-1:0] xbar_rob_ptr_t;

endpackage

// File: rtl/bank_xbar_rsp_rob_if.sv
// rtl/bank_xbar_rsp_rob_if.sv - bank response port and per-channel alloc/release bundle
interface bank_xbar_rsp_rob_if;
  import bank_xbar_rob_pkg::*;

  logic                              sc_xbar_valid_i;
  logic                              sc_xbar_ready_o;
  xbar_ch_id_t                       sc_xbar_channel_id_i;
  xbar_rob_num_t                     sc_xbar_rob_num_i;
  logic [XBAR_DATA_W-1:0]            sc_xbar_data_i;
  logic [XBAR_NUM_CH-1:0]            ch_alloc_valid_i;
  logic [XBAR_NUM_CH-1:0]            ch_alloc_ready_o;
  logic [3*XBAR_NUM_CH-1:0]          ch_alloc_rob_num_o;
  logic [XBAR_NUM_CH-1:0]            ch_rsp_valid_o;
  logic [XBAR_NUM_CH-1:0]            ch_rsp_ready_i;
  logic [XBAR_DATA_W*XBAR_NUM_CH-1:0] ch_rsp_data_o;
  logic [4*XBAR_NUM_CH-1:0]          ch_credit_o;

  modport slave (
    input  sc_xbar_valid_i, sc_xbar_channel_id_i, sc_xbar_rob_num_i, sc_xbar_data_i,
    input  ch_alloc_valid_i, ch_rsp_ready_i,
    output sc_xbar_ready_o, ch_alloc_ready_o, ch_alloc_rob_num_o,
    output ch_rsp_valid_o, ch_rsp_data_o, ch_credit_o
  );

  modport master (
    output sc_xbar_valid_i, sc_xbar_channel_id_i, sc_xbar_rob_num_i, sc_xbar_data_i,
    output ch_alloc_valid_i, ch_rsp_ready_i,
    input  sc_xbar_ready_o, ch_alloc_ready_o, ch_alloc_rob_num_o,
    input  ch_rsp_valid_o, ch_rsp_data_o, ch_credit_o
  );

endinterface

// File: rtl/bank_xbar_rsp_rob_ch.sv
// rtl/bank_xbar_rsp_rob_ch.sv - one channel of the reorder buffer (checks under XBAR_ROB_ERR_CHK_EN)
module bank_xbar_rob_ch
  import bank_xbar_rob_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  xbar_rob_num_t          wr_rob_i,
  input  logic [XBAR_DATA_W-1:0] wr_data_i,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  output xbar_rob_num_t          alloc_rob_num_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [XBAR_DATA_W-1:0] rsp_data_o,
  output xbar_rob_ptr_t          credit_o,
  output logic                   err_o
);

  localparam xbar_rob_ptr_t DEPTH = xbar_rob_ptr_t'(XBAR_ROB_DEPTH);

  xbar_rob_ptr_t             alloc_ptr_q, alloc_ptr_d;
  xbar_rob_ptr_t             rel_ptr_q, rel_ptr_d;
  xbar_rob_ptr_t             used;
  logic [XBAR_ROB_DEPTH-1:0] vld_q, vld_d;
  logic [XBAR_DATA_W-1:0]    data_q [XBAR_ROB_DEPTH];
  logic                      err_q, err_d;
  logic                      full, alloc_fire, rel_fire, wr_store;
  xbar_rob_num_t             rel_idx;

  // Occupancy comes from the wrap-extended pointers, so 8 outstanding is distinct from empty.
  assign used            = alloc_ptr_q - rel_ptr_q;
  assign full            = (used == DEPTH);
  assign rel_idx         = xbar_rob_num_t'(rel_ptr_q);
  assign alloc_ready_o   = !full;
  assign alloc_rob_num_o = xbar_rob_num_t'(alloc_ptr_q);
  assign rsp_valid_o     = vld_q[rel_idx];
  assign rsp_data_o      = data_q[rel_idx];
  assign credit_o        = DEPTH - used;
  assign err_o           = err_q;
  assign alloc_fire      = alloc_valid_i & !full;
  assign rel_fire        = rsp_valid_o & rsp_ready_i;

`ifdef XBAR_ROB_ERR_CHK_EN
  xbar_rob_num_t wr_off;
  logic          wr_legal;

  // A slot is writable only if it lies in the allocated window and holds no response yet.
  assign wr_off   = wr_rob_i - rel_idx;
  assign wr_legal = ({1'b0, wr_off} < used) && !vld_q[wr_rob_i];
  assign wr_store = wr_en_i & wr_legal;
  assign err_d    = err_q | (wr_en_i & !wr_legal) | (alloc_valid_i & full);
`else
  assign wr_store = wr_en_i;
  assign err_d    = 1'b0;
`endif

  // Next-state for pointers and valid bits; a write lands after the release clear.
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    rel_ptr_d   = rel_ptr_q;
    vld_d       = vld_q;
    if (alloc_fire) alloc_ptr_d = alloc_ptr_q + 1'b1;
    if (rel_fire) begin
      rel_ptr_d      = rel_ptr_q + 1'b1;
      vld_d[rel_idx] = 1'b0;
    end
    if (wr_store) vld_d[wr_rob_i] = 1'b1;
  end

  // Control state register; reset discards every pending entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alloc_ptr_q <= '0;
      rel_ptr_q   <= '0;
      vld_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      rel_ptr_q   <= rel_ptr_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
    end
  end

  // Payload storage needs no reset since vld gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_store) data_q[wr_rob_i] <= wr_data_i;
  end

endmodule

// File: rtl/bank_xbar_rsp_rob.sv
// rtl/bank_xbar_rsp_rob.sv - per-channel response reorder buffer top (checks under XBAR_ROB_ERR_CHK_EN)
module bank_xbar_rsp_rob
  import bank_xbar_rob_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  bank_xbar_rsp_rob_if.slave bus,
  output logic               rob_err_o
);

  logic                   ready_q, ready_d;
  logic                   bad_err_q, bad_err_d;
  logic [XBAR_NUM_CH-1:0] ch_wr_en, alloc_ready, rsp_valid, ch_err;
  xbar_rob_num_t          alloc_rob [XBAR_NUM_CH];
  logic [XBAR_DATA_W-1:0] rsp_data  [XBAR_NUM_CH];
  xbar_rob_ptr_t          credit    [XBAR_NUM_CH];

  // Allocation guarantees space, so the bank port is always ready once out of reset.
  assign ready_d             = 1'b1;
  assign bus.sc_xbar_ready_o = ready_q;

`ifdef XBAR_ROB_ERR_CHK_EN
  logic bad_ch;
  assign bad_ch    = ready_q & bus.sc_xbar_valid_i & (int'(bus.sc_xbar_channel_id_i) >= XBAR_NUM_CH);
  assign bad_err_d = bad_err_q | bad_ch;
`else
  assign bad_err_d = 1'b0;
`endif

  assign rob_err_o = (|ch_err) | bad_err_q;

  for (genvar c = 0; c < XBAR_NUM_CH; c++) begin : g_ch
    assign ch_wr_en[c] = ready_q & bus.sc_xbar_valid_i &
                         (bus.sc_xbar_channel_id_i == xbar_ch_id_t'(c));

    bank_xbar_rob_ch u_ch (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .wr_en_i         (ch_wr_en[c]),
      .wr_rob_i        (bus.sc_xbar_rob_num_i),
      .wr_data_i       (bus.sc_xbar_data_i),
      .alloc_valid_i   (bus.ch_alloc_valid_i[c]),
      .alloc_ready_o   (alloc_ready[c]),
      .alloc_rob_num_o (alloc_rob[c]),
      .rsp_valid_o     (rsp_valid[c]),
      .rsp_ready_i     (bus.ch_rsp_ready_i[c]),
      .rsp_data_o      (rsp_data[c]),
      .credit_o        (credit[c]),
      .err_o           (ch_err[c])
    );
  end

  // Pack per-channel results onto the flat bus vectors.
  always_comb begin
    bus.ch_alloc_ready_o   = alloc_ready;
    bus.ch_rsp_valid_o     = rsp_valid;
    bus.ch_alloc_rob_num_o = '0;
    bus.ch_rsp_data_o      = '0;
    bus.ch_credit_o        = '0;
    for (int c = 0; c < XBAR_NUM_CH; c++) begin
      bus.ch_alloc_rob_num_o[c*3 +: 3]          = alloc_rob[c];
      bus.ch_rsp_data_o[c*XBAR_DATA_W +: XBAR_DATA_W] = rsp_data[c];
      bus.ch_credit_o[c*4 +: 4]                 = credit[c];
    end
  end

  // Port-ready and bad-channel sticky flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q   <= 1'b0;
      bad_err_q <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      bad_err_q <= bad_err_d;
    end
  end

endmodule

// File: tb/tb_bank_xbar_rsp_rob.sv
// tb/tb_bank_xbar_rsp_rob.sv - directed and scoreboard bench for bank_xbar_rsp_rob (XBAR_ROB_ERR_CHK_EN aware)
module tb_bank_xbar_rsp_rob;
  import bank_xbar_rob_pkg::*;

  localparam int NC = XBAR_NUM_CH;
  localparam int DW = XBAR_DATA_W;
`ifdef XBAR_ROB_ERR_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rob_err;
  int   checks = 0;
  int   errors = 0;

  bank_xbar_rsp_rob_if bus ();

  bank_xbar_rsp_rob dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .rob_err_o (rob_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rdata(int c);
    return bus.ch_rsp_data_o[c*DW +: DW];
  endfunction

  function automatic logic [3:0] rcredit(int c);
    return bus.ch_credit_o[c*4 +: 4];
  endfunction

  function automatic logic [2:0] rrob(int c);
    return bus.ch_alloc_rob_num_o[c*3 +: 3];
  endfunction

  function automatic logic [DW-1:0] mk(int tag, int i);
    return {4{32'(tag * 256 + i)}};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.sc_xbar_valid_i      = 1'b0;
    bus.sc_xbar_channel_id_i = '0;
    bus.sc_xbar_rob_num_i    = '0;
    bus.sc_xbar_data_i       = '0;
    bus.ch_alloc_valid_i     = '0;
    bus.ch_rsp_ready_i       = '0;
  endtask

  task automatic do_alloc(input logic [NC-1:0] m);
    bus.ch_alloc_valid_i = m;
    step();
    bus.ch_alloc_valid_i = '0;
  endtask

  task automatic do_write(input int c, input int r, input logic [DW-1:0] d);
    bus.sc_xbar_valid_i      = 1'b1;
    bus.sc_xbar_channel_id_i = 2'(c);
    bus.sc_xbar_rob_num_i    = 3'(r);
    bus.sc_xbar_data_i       = d;
    step();
    bus.sc_xbar_valid_i      = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.sc_xbar_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got=%0b exp=0", bus.sc_xbar_ready_o); end
    rst = 1'b0;
    step();
    checks++; if (bus.sc_xbar_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%0b exp=1", bus.sc_xbar_ready_o); end
    checks++; if (bus.ch_alloc_ready_o !== 3'b111) begin errors++; $display("FAIL reset_alloc_ready got=%b exp=111", bus.ch_alloc_ready_o); end
    checks++; if (bus.ch_rsp_valid_o !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=000", bus.ch_rsp_valid_o); end
    checks++; if (bus.ch_credit_o !== 12'h888) begin errors++; $display("FAIL reset_credit got=%h exp=888", bus.ch_credit_o); end
    checks++; if (bus.ch_alloc_rob_num_o !== 9'd0) begin errors++; $display("FAIL reset_rob_num got=%h exp=0", bus.ch_alloc_rob_num_o); end
    checks++; if (rob_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", rob_err); end
  endtask

  task automatic test_reorder();
    for (int i = 0; i < 3; i++) begin
      checks++; if (rrob(0) !== 3'(i)) begin errors++; $display("FAIL reorder_alloc_rob%0d got=%0d exp=%0d", i, rrob(0), i); end
      do_alloc(3'b001);
    end
    checks++; if (rcredit(0) !== 4'd5) begin errors++; $display("FAIL reorder_credit5 got=%0d exp=5", rcredit(0)); end
    do_write(0, 2, mk(16'hA0, 2));
    checks++; if (bus.ch_rsp_valid_o[0] !== 1'b0) begin errors++; $display("FAIL reorder_hol_block got=%b exp=0", bus.ch_rsp_valid_o[0]); end
    do_write(0, 0, mk(16'hA0, 0));
    checks++; if (bus.ch_rsp_valid_o[0] !== 1'b1) begin errors++; $display("FAIL reorder_latency got=%b exp=1", bus.ch_rsp_valid_o[0]); end
    do_write(0, 1, mk(16'hA0, 1));
    bus.ch_rsp_ready_i = 3'b001;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.ch_rsp_valid_o[0] !== 1'b1 || rdata(0) !== mk(16'hA0, i)) begin errors++; $display("FAIL reorder_rsp%0d got=%b/%h exp=1/%h", i, bus.ch_rsp_valid_o[0], rdata(0), mk(16'hA0, i)); end
      step();
    end
    bus.ch_rsp_ready_i = '0;
    checks++; if (bus.ch_rsp_valid_o[0] !== 1'b0) begin errors++; $display("FAIL reorder_empty got=%b exp=0", bus.ch_rsp_valid_o[0]); end
    checks++; if (rcredit(0) !== 4'd8) begin errors++; $display("FAIL reorder_credit8 got=%0d exp=8", rcredit(0)); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 8; i++) do_alloc(3'b010);
    checks++; if (rcredit(1) !== 4'd0) begin errors++; $display("FAIL full_credit0 got=%0d exp=0", rcredit(1)); end
    checks++; if (bus.ch_alloc_ready_o[1] !== 1'b0) begin errors++; $display("FAIL full_alloc_ready got=%b exp=0", bus.ch_alloc_ready_o[1]); end
    for (int i = 0; i < 8; i++) do_write(1, i, mk(16'hB0, i));
    bus.ch_alloc_valid_i = 3'b010;
    bus.ch_rsp_ready_i   = 3'b010;
    checks++; if (rdata(1) !== mk(16'hB0, 0)) begin errors++; $display("FAIL full_head got=%h exp=%h", rdata(1), mk(16'hB0, 0)); end
    step();
    checks++; if (rcredit(1) !== 4'd1 || rrob(1) !== 3'd0) begin errors++; $display("FAIL full_no_bypass got=%0d/%0d exp=1/0", rcredit(1), rrob(1)); end
    checks++; if (rdata(1) !== mk(16'hB0, 1)) begin errors++; $display("FAIL full_second got=%h exp=%h", rdata(1), mk(16'hB0, 1)); end
    step();
    checks++; if (rcredit(1) !== 4'd1 || rrob(1) !== 3'd1) begin errors++; $display("FAIL wrap_net_zero got=%0d/%0d exp=1/1", rcredit(1), rrob(1)); end
    bus.ch_alloc_valid_i = '0;
    for (int i = 2; i < 8; i++) begin
      checks++; if (bus.ch_rsp_valid_o[1] !== 1'b1 || rdata(1) !== mk(16'hB0, i)) begin errors++; $display("FAIL full_drain%0d got=%h exp=%h", i, rdata(1), mk(16'hB0, i)); end
      step();
    end
    bus.ch_rsp_ready_i = '0;
    checks++; if (bus.ch_rsp_valid_o[1] !== 1'b0 || rcredit(1) !== 4'd7) begin errors++; $display("FAIL full_after_drain got=%b/%0d exp=0/7", bus.ch_rsp_valid_o[1], rcredit(1)); end
    do_write(1, 0, mk(16'hB0, 8));
    bus.ch_rsp_ready_i = 3'b010;
    checks++; if (bus.ch_rsp_valid_o[1] !== 1'b1 || rdata(1) !== mk(16'hB0, 8)) begin errors++; $display("FAIL wrap_data got=%h exp=%h", rdata(1), mk(16'hB0, 8)); end
    step();
    bus.ch_rsp_ready_i = '0;
    checks++; if (rcredit(1) !== 4'd8) begin errors++; $display("FAIL wrap_credit8 got=%0d exp=8", rcredit(1)); end
  endtask

  task automatic test_stall();
    do_alloc(3'b101);
    do_alloc(3'b101);
    do_alloc(3'b001);
    do_write(2, 1, mk(16'hC0, 1));
    do_write(0, 4, mk(16'hD0, 4));
    do_write(2, 0, mk(16'hC0, 0));
    do_write(0, 3, mk(16'hD0, 3));
    do_write(0, 5, mk(16'hD0, 5));
    bus.ch_rsp_ready_i = 3'b001;
    for (int t = 0; t < 5; t++) begin
      checks++; if (bus.ch_rsp_valid_o[2] !== 1'b1 || rdata(2) !== mk(16'hC0, 0)) begin errors++; $display("FAIL stall_hold%0d got=%h exp=%h", t, rdata(2), mk(16'hC0, 0)); end
      if (t < 3) begin
        checks++; if (bus.ch_rsp_valid_o[0] !== 1'b1 || rdata(0) !== mk(16'hD0, t + 3)) begin errors++; $display("FAIL stall_ch0_%0d got=%h exp=%h", t, rdata(0), mk(16'hD0, t + 3)); end
      end else begin
        checks++; if (bus.ch_rsp_valid_o[0] !== 1'b0) begin errors++; $display("FAIL stall_ch0_empty%0d got=%b exp=0", t, bus.ch_rsp_valid_o[0]); end
      end
      step();
    end
    checks++; if (rcredit(2) !== 4'd6) begin errors++; $display("FAIL stall_credit got=%0d exp=6", rcredit(2)); end
    bus.ch_rsp_ready_i = 3'b100;
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.ch_rsp_valid_o[2] !== 1'b1 || rdata(2) !== mk(16'hC0, i)) begin errors++; $display("FAIL stall_ch2_%0d got=%h exp=%h", i, rdata(2), mk(16'hC0, i)); end
      step();
    end
    bus.ch_rsp_ready_i = '0;
    checks++; if (bus.ch_rsp_valid_o !== 3'b000 || bus.ch_credit_o !== 12'h888) begin errors++; $display("FAIL stall_final got=%b/%h exp=000/888", bus.ch_rsp_valid_o, bus.ch_credit_o); end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q [NC][$];
    logic [DW-1:0] e;
    int start [NC];
    int got   [NC];
    int wl_c  [24];
    int wl_i  [24];
    int k, cyc, j, tc, ti, pend;
    logic r;
    start[0] = 6; start[1] = 9; start[2] = 2;
    for (int c = 0; c < NC; c++) got[c] = 0;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) begin
        for (int c = 0; c < NC; c++) begin
          checks++; if (rrob(c) !== 3'((start[c] + b * 8 + i) % 8)) begin errors++; $display("FAIL rand_rob b%0d c%0d i%0d got=%0d exp=%0d", b, c, i, rrob(c), (start[c] + b * 8 + i) % 8); end
        end
        do_alloc(3'b111);
      end
      for (int c = 0; c < NC; c++)
        for (int i = 0; i < 8; i++) begin
          exp_q[c].push_back({32'(b), 32'(c), 32'(i), $urandom()});
          wl_c[c * 8 + i] = c;
          wl_i[c * 8 + i] = i;
        end
      for (int i = 23; i > 0; i--) begin
        j = $urandom_range(0, i);
        tc = wl_c[i]; wl_c[i] = wl_c[j]; wl_c[j] = tc;
        ti = wl_i[i]; wl_i[i] = wl_i[j]; wl_i[j] = ti;
      end
      k = 0;
      cyc = 0;
      pend = 24;
      while ((k < 24 || pend > 0) && cyc < 400) begin
        for (int c = 0; c < NC; c++) begin
          r = 1'($urandom_range(0, 1));
          bus.ch_rsp_ready_i[c] = r;
          if (r && bus.ch_rsp_valid_o[c]) begin
            got[c]++;
            pend--;
            checks++;
            if (exp_q[c].size() == 0) begin
              errors++; $display("FAIL rand_dup c%0d got=%h exp=none", c, rdata(c));
            end else begin
              e = exp_q[c].pop_front();
              if (rdata(c) !== e) begin errors++; $display("FAIL rand_data c%0d got=%h exp=%h", c, rdata(c), e); end
            end
          end
        end
        if (k < 24) begin
          bus.sc_xbar_valid_i      = 1'b1;
          bus.sc_xbar_channel_id_i = 2'(wl_c[k]);
          bus.sc_xbar_rob_num_i    = 3'((start[wl_c[k]] + b * 8 + wl_i[k]) % 8);
          bus.sc_xbar_data_i       = exp_q[wl_c[k]][wl_i[k] - (8 - exp_q[wl_c[k]].size())];
          k++;
        end else begin
          bus.sc_xbar_valid_i = 1'b0;
        end
        step();
        cyc++;
      end
      bus.sc_xbar_valid_i = 1'b0;
      bus.ch_rsp_ready_i  = '0;
      for (int c = 0; c < NC; c++) begin
        checks++; if (exp_q[c].size() != 0) begin errors++; $display("FAIL rand_lost b%0d c%0d got=%0d left exp=0", b, c, exp_q[c].size()); exp_q[c].delete(); end
      end
    end
    for (int c = 0; c < NC; c++) begin
      checks++; if (got[c] != 40) begin errors++; $display("FAIL rand_count c%0d got=%0d exp=40", c, got[c]); end
    end
  endtask

  task automatic test_err();
    do_write(3, 2, mk(16'hE0, 3));
    checks++; if (rob_err !== ERR_EN) begin errors++; $display("FAIL err_bad_ch got=%b exp=%b", rob_err, ERR_EN); end
    checks++; if (bus.ch_rsp_valid_o !== 3'b000) begin errors++; $display("FAIL err_bad_ch_drop got=%b exp=000", bus.ch_rsp_valid_o); end
    do_write(0, 5, mk(16'hE0, 5));
    checks++; if (rob_err !== ERR_EN) begin errors++; $display("FAIL err_unalloc got=%b exp=%b", rob_err, ERR_EN); end
    bus.ch_rsp_ready_i = 3'b111;
    for (int t = 0; t < 3; t++) begin
      checks++; if (bus.ch_rsp_valid_o !== 3'b000) begin errors++; $display("FAIL err_no_rsp%0d got=%b exp=000", t, bus.ch_rsp_valid_o); end
      step();
    end
    bus.ch_rsp_ready_i = '0;
  endtask

  task automatic test_reset_mid();
    do_alloc(3'b101);
    do_alloc(3'b101);
    do_write(0, 6, mk(16'hF0, 6));
    do_write(0, 7, mk(16'hF0, 7));
    do_write(2, 2, mk(16'hF0, 2));
    do_write(2, 3, mk(16'hF0, 3));
    checks++; if (bus.ch_rsp_valid_o !== 3'b101) begin errors++; $display("FAIL rstmid_pending got=%b exp=101", bus.ch_rsp_valid_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.ch_rsp_valid_o !== 3'b000) begin errors++; $display("FAIL rstmid_valid got=%b exp=000", bus.ch_rsp_valid_o); end
    checks++; if (bus.ch_credit_o !== 12'h888 || bus.ch_alloc_ready_o !== 3'b111) begin errors++; $display("FAIL rstmid_credit got=%h/%b exp=888/111", bus.ch_credit_o, bus.ch_alloc_ready_o); end
    checks++; if (bus.sc_xbar_ready_o !== 1'b0 || rob_err !== 1'b0) begin errors++; $display("FAIL rstmid_ready_err got=%b/%b exp=0/0", bus.sc_xbar_ready_o, rob_err); end
    @(negedge clk);
    rst = 1'b0;
    bus.ch_rsp_ready_i = 3'b111;
    for (int t = 0; t < 10; t++) begin
      step();
      checks++; if (bus.ch_rsp_valid_o !== 3'b000) begin errors++; $display("FAIL rstmid_ghost%0d got=%b exp=000", t, bus.ch_rsp_valid_o); end
    end
    bus.ch_rsp_ready_i = '0;
    checks++; if (bus.ch_credit_o !== 12'h888 || bus.sc_xbar_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_after got=%h/%b exp=888/1", bus.ch_credit_o, bus.sc_xbar_ready_o); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_reorder();
    test_full_wrap();
    test_stall();
    test_random();
    test_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
